dm_lsu: RTL
===========

Name: dm_lsu

Overview:
- Load/store unit between the MIPS execute stage and the 1K x 32 big-endian data memory (memory1kx32).
- Accepts one CPU memory request at a time and drives the memory's dm_cs/dm_rd/dm_wr/addr/D_in.
- Returns sign- or zero-extended byte, halfword or word load data.
- Implements byte and halfword stores as read-modify-write, because the memory only writes full words. Flags misaligned and out-of-range accesses.

Parameters:
- ADDR_BITS, 12, byte-address width of the data memory (4096 bytes).

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  synchronous reset, active-low; one clock domain
- req  in  1  request strobe; sampled only in IDLE
- we  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- sext  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- addr  in  32  byte address
- wdata  in  32  store data, right-justified for byte/half
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- rdata  out  32  load result; holds until the next done
- addr_err  out  1  valid with done: misaligned, out-of-range or illegal size
- dm_cs  out  1  memory chip select
- dm_rd  out  1  memory read enable
- dm_wr  out  1  memory write enable
- dm_addr  out  32  word-aligned memory address, {addr[31:2],2'b00}
- dm_din  out  32  memory write data
- dm_dout  in  32  memory read data; combinational read

Behaviour:
- Reset (reset_n=0 at posedge): state=IDLE. busy, done, addr_err, dm_cs, dm_rd, dm_wr = 0. rdata, dm_addr, dm_din = 0. Reset mid-operation aborts with no further memory write. A write in progress on that same edge is suppressed because dm_wr is forced low.
- Request capture: in IDLE with req=1, latch we, size, sext, addr, wdata. req outside IDLE is ignored; no queueing.
- Error check at capture. Error if any of:
  - size=11
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - addr[31:ADDR_BITS]!=0
- States:
  - IDLE: on req, go to ERR if error; otherwise LD if we=0, ST if word store, RMW_RD if byte/half store.
  - LD: dm_cs=dm_rd=1. Capture dm_dout into the word buffer. Go to DONE.
  - ST: dm_cs=dm_wr=1, dm_din=wdata. Go to DONE.
  - RMW_RD: dm_cs=dm_rd=1. Capture dm_dout. Go to RMW_WR.
  - RMW_WR: dm_cs=dm_wr=1, dm_din=merged word. Go to DONE.
  - ERR: no memory strobes. Go to DONE with addr_err=1.
  - DONE: done=1 for one cycle. rdata updated for loads only. Return to IDLE. A new req is accepted on the following IDLE cycle.
- Latency from the req edge to the done cycle:
  - Load, word store, error: 2 cycles.
  - Byte/half store: 3 cycles.
- Big-endian lane select, o=addr[1:0]:
  - byte o=0..3 → bits [31:24], [23:16], [15:8], [7:0]
  - half o=0 → [31:16]; o=2 → [15:0]
- Merge for byte/half stores: replace only the selected lane with wdata[7:0] or wdata[15:0]; other bytes are kept from the read word.
- Load extend: sext=1 replicates the lane MSB into the upper bits; sext=0 fills with zeros. Word loads ignore sext.
- Outside its active states, every dm_* strobe is 0. dm_rd and dm_wr are never high together.
- addr_err=1 implies no dm_wr pulse occurred for that request.

Decomposition:
- Shared package dm_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - state enum (IDLE, LD, ST, RMW_RD, RMW_WR, ERR, DONE)
- One combinational sub-module, dm_lane: inputs word, offset, size, sext, wdata. Outputs the extended load value and the merged store word. It is shared by the load and RMW paths and unit-testable standalone.

Test Plan:
- Word store then load: store addr=0x010, wdata=0xDEADBEEF. Load word at 0x010. Expect rdata=0xDEADBEEF, done 2 cycles after each req, addr_err=0.
- Byte loads: mem word at 0x010 = 0x80FF7F01.
  - lb at 0x010 → 0xFFFFFF80
  - lbu at 0x010 → 0x00000080
  - lb at 0x013 → 0x00000001
- Byte RMW: mem[0x020]=0x11223344. sb at 0x021 with wdata=0x000000AA. Expect dm_rd cycle then dm_wr with dm_din=0x11AA3344, done at cycle 3. A following lw returns 0x11AA3344.
- Half RMW/load: sh at 0x022 with wdata=0x0000BEEF over 0x11223344 → 0x1122BEEF. lh at 0x022 → 0xFFFFBEEF. lhu → 0x0000BEEF.
- Errors, each → addr_err=1 with done at 2 cycles, and no dm_cs pulse:
  - lw at 0x012
  - sh at 0x023
  - lw at 0x00001000
  - size=11
- Reset mid-RMW: assert reset_n=0 during RMW_RD of an sb. Expect IDLE and all outputs 0 next cycle, no dm_wr pulse, and the target word unchanged.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory load/store unit.
package dm_pkg;
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE, LD, ST, RMW_RD, RMW_WR, ERR, DONE
  } state_e;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;
endpackage

// File: rtl/dm_lane.sv
// Big-endian lane extract/extend for loads and lane merge for sub-word stores.
module dm_lane
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  size_e       size,
  input  logic        sext,
  input  logic [31:0] wdata,
  output logic [31:0] ld_val,
  output logic [31:0] st_word
);
  logic [7:0]  b;
  logic [15:0] h;

  // Byte lane 0 is the most significant byte of the word.
  assign b = word[8*(3-offset) +: 8];
  assign h = offset[1] ? word[15:0] : word[31:16];

  always_comb begin
    ld_val = word;
    case (size)
      SZ_BYTE: ld_val = {{24{sext & b[7]}}, b};
      SZ_HALF: ld_val = {{16{sext & h[15]}}, h};
      default: ld_val = word;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [1:0] IDX = 2'(i);
    logic       sel;
    logic [7:0] nb;
    assign sel = (size == SZ_WORD) ||
                 (size == SZ_BYTE && offset == IDX) ||
                 (size == SZ_HALF && offset[1] == IDX[1]);
    always_comb begin
      nb = wdata[LANE_W*(3-i) +: LANE_W];
      if (size == SZ_BYTE)      nb = wdata[7:0];
      else if (size == SZ_HALF) nb = IDX[0] ? wdata[7:0] : wdata[15:8];
    end
    assign st_word[LANE_W*(3-i) +: LANE_W] = sel ? nb : word[LANE_W*(3-i) +: LANE_W];
  end
endmodule

// File: rtl/dm_lsu.sv
// Load/store unit for the 1K x 32 big-endian data memory; sub-word stores are
// done as read-modify-write since the memory only writes full words.
module dm_lsu
  import dm_pkg::*;
#(
  parameter int ADDR_BITS = 12
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic        dm_cs,
  output logic        dm_rd,
  output logic        dm_wr,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_din,
  input  logic [31:0] dm_dout
);
  state_e      state;
  size_e       sz_q;
  logic [1:0]  off_q;
  logic        sext_q;
  logic [31:0] wd_q;
  logic        wr_q;
  logic        err;
  logic [31:0] ld_val, st_word;
  size_e       size_in;

  assign size_in = size_e'(size);
  assign err = (size_in == SZ_BAD) ||
               (size_in == SZ_HALF && addr[0]) ||
               (size_in == SZ_WORD && addr[1:0] != 2'b00) ||
               (|addr[31:ADDR_BITS]);

  // Reset on the same edge as a pending write must keep the memory untouched.
  assign dm_wr = wr_q & reset_n;

  dm_lane u_lane (
    .word   (dm_dout),
    .offset (off_q),
    .size   (sz_q),
    .sext   (sext_q),
    .wdata  (wd_q),
    .ld_val (ld_val),
    .st_word(st_word)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      addr_err <= 1'b0;
      dm_cs    <= 1'b0;
      dm_rd    <= 1'b0;
      wr_q     <= 1'b0;
      rdata    <= '0;
      dm_addr  <= '0;
      dm_din   <= '0;
      sz_q     <= SZ_BYTE;
      off_q    <= '0;
      sext_q   <= 1'b0;
      wd_q     <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          sz_q   <= size_in;
          off_q  <= addr[1:0];
          sext_q <= sext;
          wd_q   <= wdata;
          busy   <= 1'b1;
          if (err) begin
            state <= ERR;
          end else begin
            dm_addr <= {addr[31:2], 2'b00};
            dm_cs   <= 1'b1;
            if (!we) begin
              state <= LD;
              dm_rd <= 1'b1;
            end else if (size_in == SZ_WORD) begin
              state  <= ST;
              wr_q   <= 1'b1;
              dm_din <= wdata;
            end else begin
              state <= RMW_RD;
              dm_rd <= 1'b1;
            end
          end
        end
        LD: begin
          dm_cs <= 1'b0;
          dm_rd <= 1'b0;
          rdata <= ld_val;
          done  <= 1'b1;
          state <= DONE;
        end
        ST, RMW_WR: begin
          dm_cs <= 1'b0;
          wr_q  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        RMW_RD: begin
          dm_rd  <= 1'b0;
          wr_q   <= 1'b1;
          dm_din <= st_word;
          state  <= RMW_WR;
        end
        ERR: begin
          done     <= 1'b1;
          addr_err <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          done     <= 1'b0;
          addr_err <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
